// File: rtl/softex_elastic_delay_if.sv
// softex_elastic_delay_if
//   Valid/ready beat channel used on both sides of the elastic delay line.
//   valid : beat valid (producer -> consumer)
//   ready : consumer accepts (consumer -> producer)
//   data  : NUM_ROWS rows of DATA_WIDTH bits (producer -> consumer)
//   strb  : per-row strobe (producer -> consumer)
//   master modport is the producer side, slave modport the consumer side.
interface softex_elastic_delay_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROWS   = 8
) ();
  logic                                 valid;
  logic                                 ready;
  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  data;
  logic [NUM_ROWS-1:0]                  strb;

  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/softex_elastic_delay.sv
// softex_elastic_delay
//   Elastic valid/ready delay line with a run-time selectable number of
//   active register stages (0..MAX_REGS). Bubbles collapse under
//   back-pressure, data rows are captured only when their strobe is set,
//   and the live number of held beats is reported.
// Ports
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   enable_i      : global advance enable; low freezes all state
//   clear_i       : synchronous flush (wins over enable_i)
//   depth_i       : requested active depth, clamped to MAX_REGS
//   in_if         : upstream channel (slave side)
//   out_if        : downstream channel (master side)
//   occupancy_o   : beats held in active stages
//   busy_o        : occupancy_o != 0
module softex_elastic_delay #(
  parameter  int MAX_REGS   = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_ROWS   = 8,
  localparam int DW         = $clog2(MAX_REGS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [DW-1:0]           depth_i,
  softex_elastic_delay_if.slave   in_if,
  softex_elastic_delay_if.master  out_if,
  output logic [DW-1:0]           occupancy_o,
  output logic                    busy_o
);

  typedef logic [NUM_ROWS-1:0][DATA_WIDTH-1:0] rows_t;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_REGS);

  logic [DW-1:0]                   depth_q, depth_d, depth_clamp;
  logic [DW-1:0]                   occ_q, occ_d;
  logic [MAX_REGS-1:0]             valid_q, valid_d;
  logic [MAX_REGS-1:0][NUM_ROWS-1:0] strb_q, strb_d;
  rows_t [MAX_REGS-1:0]            data_q, data_d;

  logic [MAX_REGS-1:0]             adv;
  logic [MAX_REGS:0]               src_valid;
  logic [MAX_REGS:0][NUM_ROWS-1:0] src_strb;
  rows_t [MAX_REGS:0]              src_data;

  logic        pass_mode, depth_update, in_xfer, out_xfer;
  logic        in_ready, out_valid;
  rows_t       out_data;
  logic [NUM_ROWS-1:0] out_strb;

  assign depth_clamp  = (depth_i > MAX_D) ? MAX_D : depth_i;
  assign pass_mode    = (depth_q == '0);
  // Depth may only move while the pipe is empty; the switch cycle refuses input.
  assign depth_update = enable_i & ~clear_i & (occ_q == '0) & (depth_clamp != depth_q);

  // Advance chain, walked from the output stage back to stage 1 so that
  // ready_i ripples combinationally through every active stage.
  always_comb begin : adv_chain
    logic onward;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    adv    = '0;
    onward = out_if.ready;
    for (int k = MAX_REGS - 1; k >= 0; k--) begin
      if (k < int'(depth_q)) begin
        adv[k] = enable_i & (~valid_q[k] | onward);
        onward = adv[k];
      end
    end
  end

  // Source of each stage: index 0 is the input port, index k+1 is stage k.
  always_comb begin : sources
    src_valid[0] = in_if.valid & ~depth_update;
    src_strb[0]  = in_if.strb;
    src_data[0]  = in_if.data;
    for (int k = 0; k < MAX_REGS; k++) begin
      src_valid[k+1] = valid_q[k];
      src_strb[k+1]  = strb_q[k];
      src_data[k+1]  = data_q[k];
    end
  end

  always_comb begin : stage_next
    valid_d = valid_q;
    strb_d  = strb_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = '0;
      strb_d  = '0;
      data_d  = '0;
    end else begin
      for (int k = 0; k < MAX_REGS; k++) begin
        if (adv[k]) begin
          valid_d[k] = src_valid[k];
          strb_d[k]  = src_strb[k];
          // Rows without a live strobe keep their old contents.
          for (int r = 0; r < NUM_ROWS; r++) begin
            if (src_valid[k] && src_strb[k][r]) data_d[k][r] = src_data[k][r];
          end
        end
      end
    end
  end

  always_comb begin : handshake
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_strb  = '0;
    if (pass_mode) begin
      in_ready  = enable_i & ~rst_i & ~clear_i & ~depth_update & out_if.ready;
      out_valid = enable_i & ~clear_i & ~depth_update & in_if.valid;
      out_data  = in_if.data;
      out_strb  = in_if.strb;
    end else begin
      in_ready = enable_i & ~rst_i & ~clear_i & ~depth_update & adv[0];
      for (int k = 0; k < MAX_REGS; k++) begin
        if (int'(depth_q) == k + 1) begin
          out_valid = enable_i & ~clear_i & valid_q[k];
          out_data  = data_q[k];
          out_strb  = strb_q[k];
        end
      end
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_data;
  assign out_if.strb  = out_strb;

  assign in_xfer  = in_if.valid & in_ready;
  assign out_xfer = out_valid & out_if.ready;

  always_comb begin : ctrl_next
    depth_d = depth_q;
    occ_d   = occ_q;
    if (clear_i) begin
      depth_d = depth_clamp;
      occ_d   = '0;
    end else begin
      if (depth_update) depth_d = depth_clamp;
      if (pass_mode)               occ_d = '0;
      else if (in_xfer && !out_xfer) occ_d = occ_q + 1'b1;
      else if (!in_xfer && out_xfer) occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      depth_q <= MAX_D;
      occ_q   <= '0;
      valid_q <= '0;
      strb_q  <= '0;
      // NOTE: data rows are reset too because data_o must read zero out of reset.
      data_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments only.
      depth_q <= depth_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
    end
  end

  assign occupancy_o = occ_q;
  assign busy_o      = (occ_q != '0);

endmodule

// File: tb/tb_softex_elastic_delay.sv
// Directed testbench for softex_elastic_delay (MAX_REGS=4, 16-bit rows, 8 rows).
module tb_softex_elastic_delay;

  localparam int MAX_REGS = 4;
  localparam int DWID     = 16;
  localparam int ROWS     = 8;
  localparam int DW       = $clog2(MAX_REGS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear;
  logic [DW-1:0] depth;
  logic [DW-1:0] occupancy;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  softex_elastic_delay_if #(.DATA_WIDTH(DWID), .NUM_ROWS(ROWS)) in_if ();
  softex_elastic_delay_if #(.DATA_WIDTH(DWID), .NUM_ROWS(ROWS)) out_if ();

  softex_elastic_delay #(
    .MAX_REGS  (MAX_REGS),
    .DATA_WIDTH(DWID),
    .NUM_ROWS  (ROWS)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .clear_i    (clear),
    .depth_i    (depth),
    .in_if      (in_if),
    .out_if     (out_if),
    .occupancy_o(occupancy),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] fill(input logic [15:0] v);
    return {ROWS{v}};
  endfunction

  logic [ROWS-1:0][DWID-1:0] y_in, y_exp;

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    clear        = 1'b0;
    depth        = 3'd4;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.strb   = 8'hFF;
    out_if.ready = 1'b1;

    // ---- reset state ----
    #2;
    check("rst_valid_o", out_if.valid, 0);
    check("rst_ready_o", in_if.ready, 0);
    check("rst_data_o", out_if.data, 0);
    check("rst_strb_o", out_if.strb, 0);
    check("rst_occ", occupancy, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; enable = 1'b1;
    #1;
    // depth_q resets to MAX_REGS, so depth_i=4 needs no update cycle
    check("rst_depth_max_ready", in_if.ready, 1);
    tick();

    // ---- stream 10 beats at depth 3 ----
    depth = 3'd3;
    #1;
    check("t1_depth_upd_ready", in_if.ready, 0);
    tick();
    check("t1_ready_after_upd", in_if.ready, 1);
    for (int c = 0; c < 14; c++) begin
      in_if.valid = (c < 10);
      in_if.data  = fill(16'(c + 1));
      #1;
      check($sformatf("t1_valid_c%0d", c), out_if.valid, (c >= 3 && c < 13));
      if (c >= 3 && c < 13) check($sformatf("t1_data_c%0d", c), out_if.data, fill(16'(c - 2)));
      check($sformatf("t1_occ_c%0d", c), occupancy,
            ((c < 10) ? c : 10) - ((c > 3) ? c - 3 : 0));
      if (c < 10) check($sformatf("t1_ready_c%0d", c), in_if.ready, 1);
      tick();
    end

    // ---- fill depth 3 under back-pressure ----
    out_if.ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_if.valid = 1'b1;
      in_if.data  = fill(16'h21 + 16'(b));
      #1;
      check($sformatf("t2_fill_ready_%0d", b), in_if.ready, 1);
      tick();
    end
    in_if.valid = 1'b0;
    #1;
    check("t2_full_occ", occupancy, 3);
    check("t2_full_ready", in_if.ready, 0);
    check("t2_full_valid", out_if.valid, 1);
    check("t2_full_data", out_if.data, fill(16'h21));
    enable = 1'b0;
    #1;
    check("t2_dis_valid", out_if.valid, 0);
    check("t2_dis_ready", in_if.ready, 0);
    tick();
    enable = 1'b1;
    #1;
    check("t2_dis_occ_hold", occupancy, 3);
    in_if.valid = 1'b1; in_if.data = fill(16'h24); out_if.ready = 1'b1;
    #1;
    check("t2_full_pass_ready", in_if.ready, 1);
    tick();
    in_if.valid = 1'b0;
    #1;
    check("t2_simul_occ", occupancy, 3);
    check("t2_simul_data", out_if.data, fill(16'h22));
    tick(); tick(); tick();
    check("t2_drained", occupancy, 0);

    // ---- bubble collapse at depth 4 (depth_i=7 clamps) ----
    out_if.ready = 1'b0;
    depth = 3'd7;
    #1;
    check("t3_clamp_upd_ready", in_if.ready, 0);
    tick();
    check("t3_ready", in_if.ready, 1);
    in_if.valid = 1'b1; in_if.data = fill(16'h000A);
    tick();
    in_if.valid = 1'b0;
    tick(); tick();
    in_if.valid = 1'b1; in_if.data = fill(16'h000B);
    tick();
    in_if.valid = 1'b0;
    tick(); tick();
    check("t3_occ", occupancy, 2);
    check("t3_ready_o", in_if.ready, 1);
    check("t3_valid_o", out_if.valid, 1);
    check("t3_data_a", out_if.data, fill(16'h000A));
    out_if.ready = 1'b1;
    tick();
    check("t3_valid_b", out_if.valid, 1);
    check("t3_data_b", out_if.data, fill(16'h000B));
    tick();
    check("t3_empty", occupancy, 0);
    check("t3_busy", busy, 0);

    // ---- partial strobe ----
    for (int r = 0; r < ROWS; r++) begin
      y_in[r]  = 16'h5000 + 16'(r);
      y_exp[r] = (r == 0 || r == 2) ? y_in[r] : 16'hFFFF;
    end
    in_if.valid = 1'b1; in_if.data = fill(16'hFFFF); in_if.strb = 8'hFF;
    tick();
    in_if.data = y_in; in_if.strb = 8'b0000_0101;
    tick();
    in_if.valid = 1'b0; in_if.strb = 8'hFF;
    tick(); tick();
    check("t4_prev_data", out_if.data, fill(16'hFFFF));
    check("t4_prev_strb", out_if.strb, 8'hFF);
    tick();
    check("t4_strb_data", out_if.data, y_exp);
    check("t4_strb_o", out_if.strb, 8'b0000_0101);
    tick();

    // ---- depth change with beats in flight ----
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = fill(16'h00C1);
    tick();
    in_if.data = fill(16'h00C2);
    tick();
    in_if.valid = 1'b0;
    check("t5_occ2", occupancy, 2);
    depth = 3'd1;
    #1;
    check("t5_no_upd_ready", in_if.ready, 1);
    tick(); tick();
    check("t5_old_depth_valid", out_if.valid, 1);
    check("t5_old_depth_data", out_if.data, fill(16'h00C1));
    out_if.ready = 1'b1;
    tick();
    check("t5_data_c2", out_if.data, fill(16'h00C2));
    tick();
    check("t5_drained", occupancy, 0);
    check("t5_upd_ready", in_if.ready, 0);
    tick();
    check("t5_ready_d1", in_if.ready, 1);
    in_if.valid = 1'b1; in_if.data = fill(16'h00E1);
    tick();
    in_if.valid = 1'b0;
    check("t5_lat1_valid", out_if.valid, 1);
    check("t5_lat1_data", out_if.data, fill(16'h00E1));
    tick();
    check("t5_lat1_gone", out_if.valid, 0);

    // ---- depth 0 pass-through ----
    depth = 3'd0;
    #1;
    check("t6_upd_ready", in_if.ready, 0);
    tick();
    in_if.valid = 1'b1; in_if.data = fill(16'h0F0F); in_if.strb = 8'h3C;
    #1;
    check("t6_valid", out_if.valid, 1);
    check("t6_ready", in_if.ready, 1);
    check("t6_data", out_if.data, fill(16'h0F0F));
    check("t6_strb", out_if.strb, 8'h3C);
    check("t6_occ", occupancy, 0);
    out_if.ready = 1'b0;
    #1;
    check("t6_ready_follow", in_if.ready, 0);
    in_if.valid = 1'b0;
    #1;
    check("t6_valid_follow", out_if.valid, 0);
    in_if.strb = 8'hFF;
    tick();

    // ---- clear mid-stream ----
    depth = 3'd4;
    #1;
    check("t7_upd_ready", in_if.ready, 0);
    tick();
    in_if.valid = 1'b1; in_if.data = fill(16'h1111);
    tick();
    in_if.data = fill(16'h2222);
    tick();
    in_if.valid = 1'b0;
    tick(); tick();
    check("t7_occ2", occupancy, 2);
    check("t7_valid_pre", out_if.valid, 1);
    clear = 1'b1;
    #1;
    check("t7_clr_valid", out_if.valid, 0);
    check("t7_clr_ready", in_if.ready, 0);
    tick();
    clear = 1'b0;
    #1;
    check("t7_post_occ", occupancy, 0);
    check("t7_post_valid", out_if.valid, 0);
    check("t7_post_data", out_if.data, 0);
    check("t7_post_busy", busy, 0);
    check("t7_post_ready", in_if.ready, 1);

    // ---- asynchronous reset mid-stream ----
    out_if.ready = 1'b1;
    depth = 3'd2;
    #1;
    check("t8_upd_ready", in_if.ready, 0);
    tick();
    in_if.valid = 1'b1; in_if.data = fill(16'h7777);
    tick();
    in_if.valid = 1'b0;
    tick();
    check("t8_valid_pre", out_if.valid, 1);
    check("t8_data_pre", out_if.data, fill(16'h7777));
    depth = 3'd4;
    #2;
    rst = 1'b1;
    #1;
    check("t8_rst_valid", out_if.valid, 0);
    check("t8_rst_data", out_if.data, 0);
    check("t8_rst_strb", out_if.strb, 0);
    check("t8_rst_occ", occupancy, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_ready", in_if.ready, 0);
    #1;
    rst = 1'b0;
    #1;
    check("t8_depth_max_ready", in_if.ready, 1);
    in_if.valid = 1'b1; in_if.data = fill(16'h4444);
    tick();
    in_if.valid = 1'b0;
    tick(); tick();
    check("t8_lat4_not_yet", out_if.valid, 0);
    tick();
    check("t8_lat4_valid", out_if.valid, 1);
    check("t8_lat4_data", out_if.data, fill(16'h4444));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
